// File: rtl/ram_bist_pkg.sv
// Shared types and March C- tables for the RAM BIST controller.
package ram_bist_pkg;
   typedef enum logic [2:0] {E0, E1, E2, E3, E4, E5} elem_e;
   typedef enum logic {OP_R, OP_W} op_e;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

   // Bit n describes element En: descending order, read background, write background.
   localparam logic [5:0] DESC_TBL = 6'b011000;
   localparam logic [5:0] RBG_TBL  = 6'b010100;
   localparam logic [5:0] WBG_TBL  = 6'b001010;

   // E0 is a lone write and E5 a lone read; the rest are read-then-write.
   function automatic op_e op_of(elem_e e, logic idx);
      if (e == E0) return OP_W;
      if (e == E5) return OP_R;
      return idx ? OP_W : OP_R;
   endfunction

   function automatic logic last_op(elem_e e, logic idx);
      return (e == E0 || e == E5) ? 1'b1 : idx;
   endfunction
endpackage

// File: rtl/ram_bist_seq.sv
// March C- sequencer: walks elements, addresses and ops, holding reads for 1+RD_LAT cycles.
module ram_bist_seq
   import ram_bist_pkg::*;
#(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 4,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              clr,
   output logic [ADDR_W-1:0] sel,
   output logic              rw,
   output logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] expected,
   output logic              cmp,
   output logic              last,
   output logic [2:0]        elem_o
);
   localparam int WC_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

   elem_e             elem;
   logic [ADDR_W-1:0] idx;
   logic              op_idx;
   logic [WC_W-1:0]   wcnt;
   op_e               op;
   logic              op_done;

   always_comb begin
      op       = op_of(elem, op_idx);
      rw       = (op == OP_W) ? RW_WRITE : RW_READ;
      sel      = DESC_TBL[elem] ? ~idx : idx;
      wdata    = {DATA_W{WBG_TBL[elem]}};
      expected = {DATA_W{RBG_TBL[elem]}};
      op_done  = (op == OP_W) || (wcnt == WC_W'(RD_LAT));
      cmp      = (op == OP_R) && op_done;
      last     = (elem == E5) && (&idx) && op_done;
   end

   assign elem_o = elem;

   always_ff @(posedge clk) begin
      if (clr) begin
         elem   <= E0;
         idx    <= '0;
         op_idx <= 1'b0;
         wcnt   <= '0;
      end else if (op_done) begin
         wcnt <= '0;
         if (!last_op(elem, op_idx)) begin
            op_idx <= 1'b1;
         end else begin
            op_idx <= 1'b0;
            idx    <= idx + ADDR_W'(1);
            if (&idx) elem <= elem_e'(elem + 3'd1);
         end
      end else begin
         wcnt <= wcnt + WC_W'(1);
      end
   end
endmodule

// File: rtl/ram_bist_ctrl.sv
// BIST controller and functional access mux in front of the RAM array.
module ram_bist_ctrl
   import ram_bist_pkg::*;
#(
   parameter int ADDR_W       = 2,
   parameter int DATA_W       = 4,
   parameter int RD_LAT       = 1,
   parameter int STOP_ON_FAIL = 1
) (
   input  logic              clk,
   input  logic              rst_i,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              pass_o,
   output logic [2:0]        fail_elem_o,
   output logic [ADDR_W-1:0] fail_addr_o,
   output logic [DATA_W-1:0] fail_mask_o,
   input  logic [ADDR_W-1:0] func_sel_i,
   input  logic              func_rw_i,
   input  logic [DATA_W-1:0] func_data_i,
   output logic [DATA_W-1:0] func_data_o,
   output logic [ADDR_W-1:0] ram_sel_o,
   output logic              ram_rw_o,
   output logic [DATA_W-1:0] ram_data_o,
   input  logic [DATA_W-1:0] ram_data_i
);
   state_e            state;
   logic              fail_seen;
   logic [ADDR_W-1:0] s_sel;
   logic              s_rw, s_cmp, s_last;
   logic [DATA_W-1:0] s_wdata, s_exp;
   logic [2:0]        s_elem;
   logic              mismatch;

   // Sequencer sits at its first op whenever the march is not running.
   ram_bist_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_seq (
      .clk      (clk),
      .clr      (rst_i || state != S_RUN),
      .sel      (s_sel),
      .rw       (s_rw),
      .wdata    (s_wdata),
      .expected (s_exp),
      .cmp      (s_cmp),
      .last     (s_last),
      .elem_o   (s_elem)
   );

   assign mismatch    = s_cmp && (ram_data_i != s_exp);
   assign func_data_o = ram_data_i;

   always_comb begin
      ram_sel_o  = func_sel_i;
      ram_rw_o   = func_rw_i;
      ram_data_o = func_data_i;
      if (state == S_RUN) begin
         ram_sel_o  = s_sel;
         ram_rw_o   = s_rw;
         ram_data_o = s_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         state       <= S_IDLE;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         pass_o      <= 1'b0;
         fail_elem_o <= '0;
         fail_addr_o <= '0;
         fail_mask_o <= '0;
         fail_seen   <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: if (start_i) begin
               state       <= S_RUN;
               busy_o      <= 1'b1;
               done_o      <= 1'b0;
               pass_o      <= 1'b0;
               fail_elem_o <= '0;
               fail_addr_o <= '0;
               fail_mask_o <= '0;
               fail_seen   <= 1'b0;
            end
            S_RUN: begin
               if (mismatch && !fail_seen) begin
                  fail_seen   <= 1'b1;
                  fail_elem_o <= s_elem;
                  fail_addr_o <= s_sel;
                  fail_mask_o <= ram_data_i ^ s_exp;
               end
               if (s_last || (mismatch && STOP_ON_FAIL != 0)) begin
                  state  <= S_DONE;
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
                  pass_o <= !(fail_seen || mismatch);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench: three controllers (default, run-to-end, RD_LAT=2) each on a stuck-at RAM model.
module tb_ram_bist_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst [3], start [3], busy [3], done [3], pass [3];
   logic [2:0] f_elem [3];
   logic [1:0] f_addr [3];
   logic [3:0] f_mask [3];
   logic [1:0] fsel [3], rsel [3];
   logic       frw [3], rrw [3];
   logic [3:0] fdi [3], fdo [3], rwd [3], rrd [3];
   logic [3:0] sa1 [3][4];
   logic [3:0] sa0 [3][4];
   int nvec = 0, nerr = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int LAT = (g == 2) ? 2 : 1;
      logic [3:0] mem [4];
      logic [3:0] rv, rp1, rp2;
      assign rv = (mem[rsel[g]] | sa1[g][rsel[g]]) & ~sa0[g][rsel[g]];
      always @(posedge clk) begin
         if (rrw[g]) mem[rsel[g]] <= rwd[g];
         rp1 <= rv;
         rp2 <= rp1;
      end
      assign rrd[g] = (LAT == 2) ? rp2 : rp1;

      ram_bist_ctrl #(.ADDR_W(2), .DATA_W(4), .RD_LAT(LAT), .STOP_ON_FAIL((g == 1) ? 0 : 1)) u_dut (
         .clk(clk), .rst_i(rst[g]), .start_i(start[g]),
         .busy_o(busy[g]), .done_o(done[g]), .pass_o(pass[g]),
         .fail_elem_o(f_elem[g]), .fail_addr_o(f_addr[g]), .fail_mask_o(f_mask[g]),
         .func_sel_i(fsel[g]), .func_rw_i(frw[g]), .func_data_i(fdi[g]), .func_data_o(fdo[g]),
         .ram_sel_o(rsel[g]), .ram_rw_o(rrw[g]), .ram_data_o(rwd[g]), .ram_data_i(rrd[g])
      );
   end

   // Reference: walk March C- on an abstract memory with one stuck bit, counting op cycles.
   function automatic void model(input int stop, input int lat, input bit fen, input int fa,
                                 input int fb, input bit fv, output bit mpass, output int melem,
                                 output int maddr, output int mmask, output int cycles);
      int mem [4];
      int cyc = 0;
      int a, v, rexp;
      mpass = 1; melem = 0; maddr = 0; mmask = 0;
      for (int e = 0; e < 6; e++) begin
         for (int k = 0; k < 4; k++) begin
            a = (e == 3 || e == 4) ? 3 - k : k;
            if (e != 0) begin
               rexp = (e == 2 || e == 4) ? 15 : 0;
               cyc += 1 + lat;
               v = mem[a];
               if (fen && a == fa) v = fv ? (v | (1 << fb)) : (v & ~(1 << fb));
               if (v != rexp && mpass) begin
                  mpass = 0; melem = e; maddr = a; mmask = v ^ rexp;
                  if (stop != 0) begin
                     cycles = cyc;
                     return;
                  end
               end
            end
            if (e != 5) begin
               mem[a] = (e == 1 || e == 3) ? 15 : 0;
               cyc += 1;
            end
         end
      end
      cycles = cyc;
   endfunction

   task automatic set_fault(input int i, input bit en, input int a, input int b, input bit v);
      for (int k = 0; k < 4; k++) begin
         sa1[i][k] = 4'h0;
         sa0[i][k] = 4'h0;
      end
      if (en) begin
         if (v) sa1[i][a] = 4'(1 << b);
         else   sa0[i][a] = 4'(1 << b);
      end
   endtask

   // Pulse start and count cycles (cycle 1 = period after the start edge) until done_o.
   task automatic do_run(input int i, input int restart_at, output int dcyc, output int busy_bad,
                         output logic [11:0] snap);
      int n;
      @(negedge clk);
      start[i] = 1'b1;
      @(posedge clk);
      #1 start[i] = 1'b0;
      n = 1;
      busy_bad = 0;
      snap = {busy[i], done[i], pass[i], f_elem[i], f_addr[i], f_mask[i]};
      while (done[i] !== 1'b1 && n < 400) begin
         if (busy[i] !== 1'b1) busy_bad++;
         if (n == restart_at) start[i] = 1'b1;
         @(posedge clk);
         #1 start[i] = 1'b0;
         n++;
      end
      dcyc = (done[i] === 1'b1) ? n : -1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         nvec++;
         if ({busy[i], done[i], pass[i], f_elem[i], f_addr[i], f_mask[i]} !== 12'h0) begin
            nerr++;
            $display("FAIL reset_outputs inst%0d got %b want 0", i,
                     {busy[i], done[i], pass[i], f_elem[i], f_addr[i], f_mask[i]});
         end
         fsel[i] = 2'd1; frw[i] = 1'b1; fdi[i] = 4'h6;
         #1;
         nvec++;
         if ({rsel[i], rrw[i], rwd[i]} !== {2'd1, 1'b1, 4'h6}) begin
            nerr++;
            $display("FAIL reset_passthru inst%0d got %h want %h", i, {rsel[i], rrw[i], rwd[i]},
                     {2'd1, 1'b1, 4'h6});
         end
         frw[i] = 1'b0;
      end
   endtask

   task automatic test_march_pass();
      int d, bb;
      logic [11:0] s;
      set_fault(0, 0, 0, 0, 0);
      do_run(0, 0, d, bb, s);
      nvec++;
      if (d !== 61 || bb !== 0) begin
         nerr++; $display("FAIL pass_timing done_cycle %0d busy_gaps %0d want 61/0", d, bb);
      end
      nvec++;
      if ({pass[0], f_elem[0], f_addr[0], f_mask[0]} !== {1'b1, 9'h0}) begin
         nerr++; $display("FAIL pass_result got %h want %h", {pass[0], f_elem[0], f_addr[0], f_mask[0]},
                          {1'b1, 9'h0});
      end
      repeat (3) @(posedge clk);
      #1;
      nvec++;
      if (done[0] !== 1'b1 || busy[0] !== 1'b0) begin
         nerr++; $display("FAIL done_hold done %b busy %b want 1/0", done[0], busy[0]);
      end
   endtask

   task automatic test_stuck_stop();
      int d, bb;
      logic [11:0] s;
      set_fault(0, 1, 1, 2, 1);
      do_run(0, 0, d, bb, s);
      nvec++;
      if (d !== 10) begin
         nerr++; $display("FAIL stop_timing done_cycle %0d want 10", d);
      end
      nvec++;
      if ({pass[0], f_elem[0], f_addr[0], f_mask[0]} !== {1'b0, 3'd1, 2'd1, 4'b0100}) begin
         nerr++; $display("FAIL stop_result got %h want %h", {pass[0], f_elem[0], f_addr[0], f_mask[0]},
                          {1'b0, 3'd1, 2'd1, 4'b0100});
      end
   endtask

   task automatic test_stuck_full();
      int d, bb;
      logic [11:0] s;
      set_fault(1, 1, 3, 0, 0);
      do_run(1, 0, d, bb, s);
      nvec++;
      if (d !== 61) begin
         nerr++; $display("FAIL full_timing done_cycle %0d want 61", d);
      end
      nvec++;
      if ({pass[1], f_elem[1], f_addr[1], f_mask[1]} !== {1'b0, 3'd2, 2'd3, 4'b0001}) begin
         nerr++; $display("FAIL full_result got %h want %h", {pass[1], f_elem[1], f_addr[1], f_mask[1]},
                          {1'b0, 3'd2, 2'd3, 4'b0001});
      end
      set_fault(1, 0, 0, 0, 0);
   endtask

   task automatic test_passthrough();
      int d, bb;
      logic [11:0] s;
      set_fault(0, 0, 0, 0, 0);
      @(negedge clk);
      fsel[0] = 2'd2; frw[0] = 1'b1; fdi[0] = 4'hA;
      #1;
      nvec++;
      if ({rsel[0], rrw[0], rwd[0]} !== {2'd2, 1'b1, 4'hA}) begin
         nerr++; $display("FAIL idle_mux got %h want %h", {rsel[0], rrw[0], rwd[0]}, {2'd2, 1'b1, 4'hA});
      end
      @(negedge clk);
      frw[0] = 1'b0;
      @(posedge clk);
      #1;
      nvec++;
      if (fdo[0] !== 4'hA) begin
         nerr++; $display("FAIL idle_read got %h want a", fdo[0]);
      end
      // Functional write held throughout a march must not reach the RAM.
      fsel[0] = 2'd2; frw[0] = 1'b1; fdi[0] = 4'h5;
      @(negedge clk);
      start[0] = 1'b1;
      @(posedge clk);
      #1 start[0] = 1'b0;
      nvec++;
      if ({rsel[0], rwd[0]} !== {2'd0, 4'h0}) begin
         nerr++; $display("FAIL run_mux got %h want %h", {rsel[0], rwd[0]}, {2'd0, 4'h0});
      end
      d = 0;
      while (done[0] !== 1'b1 && d < 400) begin
         @(posedge clk);
         #1 d++;
      end
      frw[0] = 1'b0;
      @(posedge clk);
      #1;
      nvec++;
      if (fdo[0] !== 4'h0 || pass[0] !== 1'b1) begin
         nerr++; $display("FAIL run_ignores_func read %h pass %b want 0/1", fdo[0], pass[0]);
      end
      bb = 0; s = '0;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      start[0] = 1'b1;
      @(posedge clk);
      #1 start[0] = 1'b0;
      repeat (31) @(posedge clk);
      #1;
      nvec++;
      if (busy[0] !== 1'b1) begin
         nerr++; $display("FAIL mid_busy got %b want 1", busy[0]);
      end
      rst[0] = 1'b1;
      fsel[0] = 2'd3; frw[0] = 1'b0; fdi[0] = 4'h9;
      @(posedge clk);
      #1;
      nvec++;
      if ({busy[0], done[0], pass[0], f_elem[0], f_addr[0], f_mask[0], rsel[0], rrw[0], rwd[0]}
          !== {12'h0, 2'd3, 1'b0, 4'h9}) begin
         nerr++; $display("FAIL mid_reset got %h want %h",
                          {busy[0], done[0], pass[0], f_elem[0], f_addr[0], f_mask[0], rsel[0], rrw[0], rwd[0]},
                          {12'h0, 2'd3, 1'b0, 4'h9});
      end
      rst[0] = 1'b0;
   endtask

   task automatic test_start_ignored();
      int d, bb;
      logic [11:0] s;
      do_run(0, 10, d, bb, s);
      nvec++;
      if (d !== 61 || pass[0] !== 1'b1) begin
         nerr++; $display("FAIL start_in_run done_cycle %0d pass %b want 61/1", d, pass[0]);
      end
   endtask

   task automatic test_rerun();
      int d, bb;
      logic [11:0] s;
      set_fault(0, 1, 2, 3, 0);
      do_run(0, 0, d, bb, s);
      set_fault(0, 0, 0, 0, 0);
      do_run(0, 0, d, bb, s);
      nvec++;
      if (s !== 12'b1000_0000_0000) begin
         nerr++; $display("FAIL rerun_cleared got %b want 100000000000", s);
      end
      nvec++;
      if (d !== 61 || pass[0] !== 1'b1 || f_mask[0] !== 4'h0) begin
         nerr++; $display("FAIL rerun_result done_cycle %0d pass %b mask %h want 61/1/0", d, pass[0], f_mask[0]);
      end
   endtask

   task automatic test_rdlat2();
      int d, bb;
      logic [11:0] s;
      set_fault(2, 0, 0, 0, 0);
      do_run(2, 0, d, bb, s);
      nvec++;
      if (d !== 81 || bb !== 0 || pass[2] !== 1'b1) begin
         nerr++; $display("FAIL rdlat2 done_cycle %0d busy_gaps %0d pass %b want 81/0/1", d, bb, pass[2]);
      end
   endtask

   task automatic test_random();
      int i, fa, fb, d, bb, melem, maddr, mmask, cyc;
      bit fen, fv, mpass;
      logic [11:0] s;
      for (int it = 0; it < 12; it++) begin
         i   = $urandom_range(0, 2);
         fen = ($urandom_range(0, 3) != 0);
         fa  = $urandom_range(0, 3);
         fb  = $urandom_range(0, 3);
         fv  = 1'($urandom_range(0, 1));
         set_fault(i, fen, fa, fb, fv);
         model((i == 1) ? 0 : 1, (i == 2) ? 2 : 1, fen, fa, fb, fv, mpass, melem, maddr, mmask, cyc);
         do_run(i, 0, d, bb, s);
         nvec++;
         if (d !== cyc + 1 || bb !== 0) begin
            nerr++; $display("FAIL rand_timing it%0d inst%0d done_cycle %0d busy_gaps %0d want %0d/0",
                             it, i, d, bb, cyc + 1);
         end
         nvec++;
         if ({pass[i], f_elem[i], f_addr[i], f_mask[i]} !== {mpass, 3'(melem), 2'(maddr), 4'(mmask)}) begin
            nerr++; $display("FAIL rand_result it%0d inst%0d got %h want %h", it, i,
                             {pass[i], f_elem[i], f_addr[i], f_mask[i]},
                             {mpass, 3'(melem), 2'(maddr), 4'(mmask)});
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1; start[i] = 1'b0;
         fsel[i] = 2'd0; frw[i] = 1'b0; fdi[i] = 4'h0;
         set_fault(i, 0, 0, 0, 0);
      end
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) rst[i] = 1'b0;
      test_reset();
      test_march_pass();
      test_stuck_stop();
      test_stuck_full();
      test_passthrough();
      test_reset_mid();
      test_start_ignored();
      test_rerun();
      test_rdlat2();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/ram_bist_ctrl.md
Name: ram_bist_ctrl

Overview:
- Built-in self-test controller and access mux that sits directly upstream of the 4x4 RAM array.
- It drives the RAM's line-select, read/write and write-data inputs and consumes its read data.
- On start it runs a March C- sequence over all words and reports pass/fail with first-failure diagnostics.
- When idle it passes functional accesses straight through to the RAM.

Parameters:
- ADDR_W, 2: RAM line-select width; depth = 2**ADDR_W.
- DATA_W, 4: RAM word width.
- RD_LAT, 1: cycles from a read command at the RAM inputs to valid data at ram_data_i (>=0).
- STOP_ON_FAIL, 1: 1 = abort to DONE on first mismatch; 0 = finish the full march.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  start BIST; sampled in IDLE or DONE.
- busy_o  output  1  BIST running; functional inputs ignored.
- done_o  output  1  BIST finished; held until next start or reset.
- pass_o  output  1  valid when done_o=1; 1 = no mismatch.
- fail_elem_o  output  3  march element (0..5) of first mismatch.
- fail_addr_o  output  ADDR_W  address of first mismatch.
- fail_mask_o  output  DATA_W  read XOR expected at first mismatch.
- func_sel_i  input  ADDR_W  functional line select.
- func_rw_i  input  1  functional rw (1 = write, 0 = read).
- func_data_i  input  DATA_W  functional write data.
- func_data_o  output  DATA_W  always equals ram_data_i.
- ram_sel_o  output  ADDR_W  to RAM line select.
- ram_rw_o  output  1  to RAM rw (1 = write, 0 = read).
- ram_data_o  output  DATA_W  to RAM write data.
- ram_data_i  input  DATA_W  RAM read data.

Behaviour:
- Reset:
  - state=IDLE.
  - busy_o=0, done_o=0, pass_o=0, fail_elem_o=0, fail_addr_o=0, fail_mask_o=0.
  - ram_* follow func_* (pass-through).
  - Reset mid-march aborts immediately; nothing is held.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE: ram_sel_o/ram_rw_o/ram_data_o = func_* combinationally.
  - start_i=1 in IDLE or DONE -> RUN next edge. This clears done_o, pass_o and all fail_* outputs, and sets busy_o.
  - start_i in RUN is ignored.
  - RUN: ram_* are driven from the march sequencer; func_* are ignored.
- March C- elements (bg0 = all-zeros, bg1 = all-ones):
  - E0: ascending, W0.
  - E1: ascending, R0 W1.
  - E2: ascending, R1 W0.
  - E3: descending, R0 W1.
  - E4: descending, R1 W0.
  - E5: ascending, R0.
  - Ascending = 0..depth-1; descending = depth-1..0.
- Op timing:
  - Write: 1 cycle, ram_rw_o=1.
  - Read: ram_rw_o=0 held for 1+RD_LAT cycles with sel stable. ram_data_i is compared on the last of those cycles.
  - No op overlap or pipelining.
- Cycle count: total op cycles = depth + 4*depth*(2+RD_LAT) + depth*(1+RD_LAT).
  - Defaults give 4+48+8 = 60.
  - First op occupies the cycle after the start edge.
  - done_o rises the cycle after the last op, i.e. cycle 61 counted from the start edge.
- Compare and fault capture:
  - Mismatch = ram_data_i != expected background.
  - The first mismatch latches element, address and XOR mask. Later mismatches do not overwrite it.
  - STOP_ON_FAIL=1: RUN -> DONE on the edge after the mismatching compare.
  - STOP_ON_FAIL=0: the march completes.
- In DONE: pass_o = no mismatch seen; busy_o=0.
- Address counter wraps are internal only; element advance happens on the last address of each element.

Decomposition:
- Package ram_bist_pkg:
  - element encoding E0..E5 (3 bits) and op enum {OP_R, OP_W};
  - RW_WRITE=1'b1 / RW_READ=1'b0;
  - FSM state enum;
  - per-element direction and background-constant tables.
- Sub-module ram_bist_seq: element/address/op/read-wait counters. Emits sel, rw, wdata, expected, compare strobe and last.
- Top: FSM, fault capture, pass-through mux.

Test Plan:
1. Fault-free RAM model, defaults, start pulse -> busy_o for 60 cycles, done_o=1 at cycle 61, pass_o=1, fail_* all 0.
2. Bit 2 of addr 1 stuck-at-1, start -> fail_elem_o=1, fail_addr_o=1, fail_mask_o=4'b0100, pass_o=0. done_o one cycle after the E1 read of addr 1 (STOP_ON_FAIL=1).
3. Bit 0 of addr 3 stuck-at-0, STOP_ON_FAIL=0 -> full 60-cycle run; fail_elem_o=2, fail_addr_o=3, fail_mask_o=4'b0001; later E4 mismatches do not overwrite.
4. Idle pass-through: func_sel_i=2, func_rw_i=1, func_data_i=4'hA, then read sel 2 -> ram_* mirror func_* same cycle; func_data_o=4'hA. Repeat during RUN -> func ignored, RAM contents set by march.
5. rst_i asserted mid-E3 -> next cycle IDLE, all outputs at reset values. start_i during RUN ignored; start_i in DONE reruns with results cleared.
6. RD_LAT=2 fault-free -> 4+64+12 = 80 op cycles, done_o at cycle 81, pass_o=1.
